// File: rtl/down_counter_timer_if.sv
// Bus bundle for the down-counter/timer: control inputs from the master,
// count and status outputs from the slave (the timer itself).
interface down_counter_timer_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             tc;

  modport master (
    output load, load_val, en, auto_reload,
    input  count, busy, done, tc
  );

  modport slave (
    input  load, load_val, en, auto_reload,
    output count, busy, done, tc
  );
endinterface

// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer with one-shot or periodic reload. It raises a
// one-cycle terminal-count pulse each time the count expires.
module down_counter_timer #(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  down_counter_timer_if.slave   bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [1:0]       state_q, state_d;
  logic             tc_q, tc_d;

  logic             running;
  logic             expiry;
  logic             decrement;

  // An enabled RUN cycle either expires (count==1) or decrements. A zero count
  // is never decremented, so the counter cannot wrap.
  assign running   = (state_q == ST_RUN) && bus.en;
  assign expiry    = running && (count_q == CNT_ONE);
  assign decrement = running && (count_q > CNT_ONE);

  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    state_d  = state_q;
    tc_d     = 1'b0;

    if (bus.load) begin
      count_d  = bus.load_val;
      reload_d = bus.load_val;
      state_d  = (bus.load_val != CNT_ZERO) ? ST_RUN : ST_IDLE;
    end else if (expiry) begin
      tc_d = 1'b1;
      if (bus.auto_reload) begin
        count_d = reload_q;
      end else begin
        count_d = CNT_ZERO;
        state_d = ST_DONE;
      end
    end else if (decrement) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= CNT_ZERO;
      reload_q <= CNT_ZERO;
      state_q  <= ST_IDLE;
      tc_q     <= 1'b0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      state_q  <= state_d;
      tc_q     <= tc_d;
    end
  end

  // Status flags are pure state decodes so they track the state with no lag.
  assign bus.count = count_q;
  assign bus.busy  = (state_q == ST_RUN);
  assign bus.done  = (state_q == ST_DONE);
  assign bus.tc    = tc_q;

endmodule
